// File: rtl/sram_shared_port_pkg.sv
// Shared definitions for the single-port SRAM sharing controller.
// Holds the controller state encoding and the requester-index width helper.
package sram_shared_port_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // A single requester still needs a 1-bit index.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant starting at the pointer,
// plus the pointer register that advances past each winner.
module sram_rr_arb
  import sram_shared_port_pkg::*;
#(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = idx_width(NumReq)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  input  logic              ptr_en_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o
);

  logic [IdxW-1:0] ptr_q;
  logic            found;

  // Scan upper part [ptr, NumReq) first, then the wrapped part [0, ptr).
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!found && req_i[i] && (i >= 32'(ptr_q))) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IdxW'(i);
      end
    end
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!found && req_i[i] && (i < 32'(ptr_q))) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IdxW'(i);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (ptr_en_i && found) begin
      if (idx_o == IdxW'(NumReq - 1)) begin
        ptr_q <= '0;
      end else begin
        ptr_q <= idx_o + IdxW'(1);
      end
    end
  end

endmodule

// File: rtl/sram_shared_port_ctrl.sv
// Shares one 1-cycle-latency single-port SRAM between NumReq requesters,
// with an optional zero-fill sweep of the whole array after reset.
module sram_shared_port_ctrl
  import sram_shared_port_pkg::*;
#(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned NumWords  = 512,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned ByteWidth = 8,
  parameter logic        InitZero  = 1'b1,
  parameter int unsigned AddrWidth = $clog2(NumWords),
  parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumReq-1:0]                req_i,
  output logic [NumReq-1:0]                gnt_o,
  input  logic [NumReq-1:0]                we_i,
  input  logic [NumReq-1:0][AddrWidth-1:0] addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0] wdata_i,
  input  logic [NumReq-1:0][BeWidth-1:0]   be_i,
  output logic [NumReq-1:0]                rvalid_o,
  output logic [DataWidth-1:0]             rdata_o,
  output logic                             init_done_o,
  output logic                             mem_req_o,
  output logic                             mem_we_o,
  output logic [AddrWidth-1:0]             mem_addr_o,
  output logic [DataWidth-1:0]             mem_wdata_o,
  output logic [BeWidth-1:0]               mem_be_o,
  input  logic [DataWidth-1:0]             mem_rdata_i
);

  localparam int unsigned         IdxW     = idx_width(NumReq);
  localparam logic [0:0]          S_INIT   = ST_INIT;
  localparam logic [0:0]          S_RUN    = ST_RUN;
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);

  logic [0:0]           state_q, state_d;
  logic [AddrWidth-1:0] cnt_q, cnt_d;
  logic                 live, in_init, run;
  logic [NumReq-1:0]    arb_req, arb_gnt;
  logic [IdxW-1:0]      arb_idx;
  logic                 any_gnt;
  logic                 vld_p1, rd_p1;
  logic [IdxW-1:0]      idx_p1;

  // Memory-side outputs stay quiet while reset is held, even though the
  // reset state itself is INIT.
  assign live    = ~rst_i;
  assign in_init = (state_q == S_INIT) && live;
  assign run     = (state_q == S_RUN) && live;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_INIT) begin
      if (cnt_q == LastAddr) begin
        state_d = S_RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + AddrWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= InitZero ? S_INIT : S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign arb_req = req_i & {NumReq{run}};

  sram_rr_arb #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (arb_req),
    .ptr_en_i (run),
    .gnt_o    (arb_gnt),
    .idx_o    (arb_idx)
  );

  assign any_gnt     = |arb_gnt;
  assign gnt_o       = arb_gnt;
  assign init_done_o = run;

  // Stage p0: drive the SRAM from the sweep counter or the arbitration winner.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (in_init) begin
      mem_req_o  = 1'b1;
      mem_we_o   = 1'b1;
      mem_addr_o = cnt_q;
      mem_be_o   = '1;
    end else if (any_gnt) begin
      mem_req_o   = 1'b1;
      mem_we_o    = we_i[arb_idx];
      mem_addr_o  = addr_i[arb_idx];
      mem_wdata_o = wdata_i[arb_idx];
      mem_be_o    = be_i[arb_idx];
    end
  end

  // Stage p1: remember who was granted so the response lands on that index.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1 <= 1'b0;
      rd_p1  <= 1'b0;
      idx_p1 <= '0;
    end else begin
      vld_p1 <= any_gnt;
      rd_p1  <= any_gnt && !we_i[arb_idx];
      idx_p1 <= arb_idx;
    end
  end

  assign rvalid_o = vld_p1 ? (NumReq'(1) << idx_p1) : '0;
  assign rdata_o  = (vld_p1 && rd_p1) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_sram_shared_port_ctrl.sv
// Bench for sram_shared_port_ctrl: SRAM model, reference model with a response
// scoreboard, a table of RUN-mode vectors and reset/sweep sequences.
module tb_sram_shared_port_ctrl;

  localparam int NR = 2;
  localparam int NW = 512;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int BW = 4;

  logic                   clk;
  logic                   rst;
  logic [NR-1:0]          req;
  logic [NR-1:0]          gnt_o;
  logic [NR-1:0]          we;
  logic [NR-1:0][AW-1:0]  addr;
  logic [NR-1:0][DW-1:0]  wdata;
  logic [NR-1:0][BW-1:0]  be;
  logic [NR-1:0]          rvalid_o;
  logic [DW-1:0]          rdata_o;
  logic                   init_done_o;
  logic                   mem_req_o;
  logic                   mem_we_o;
  logic [AW-1:0]          mem_addr_o;
  logic [DW-1:0]          mem_wdata_o;
  logic [BW-1:0]          mem_be_o;
  logic [DW-1:0]          mem_rdata;

  sram_shared_port_ctrl #(
    .NumReq    (NR),
    .NumWords  (NW),
    .DataWidth (DW),
    .ByteWidth (8),
    .InitZero  (1'b1)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .gnt_o       (gnt_o),
    .we_i        (we),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .be_i        (be),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .init_done_o (init_done_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_be_o    (mem_be_o),
    .mem_rdata_i (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural tc_sram, 1-cycle read latency, preloaded with garbage.
  logic [DW-1:0] sram [NW];
  initial begin
    for (int i = 0; i < NW; i++) sram[i] = $urandom;
    mem_rdata = '0;
  end
  always @(posedge clk) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < BW; b++)
          if (mem_be_o[b]) sram[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
      end else begin
        mem_rdata <= sram[mem_addr_o];
      end
    end
  end

  typedef struct {
    int          idx;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t q[$];

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] ref_mem [NW];
  logic m_run;
  int   m_cnt;
  int   m_ptr;
  int   init_cycles;
  logic [NR-1:0] s_gnt, s_rv;
  logic [DW-1:0] s_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: sample at negedge, compare against model, advance model.
  task automatic step();
    int w;
    int j;
    int a;
    rsp_t e;
    logic [NR-1:0] eg;
    @(negedge clk);
    s_gnt = gnt_o;
    s_rv  = rvalid_o;
    s_rd  = rdata_o;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("rvalid", 64'(rvalid_o), 64'(NR'(1) << e.idx));
      check("rdata", 64'(rdata_o), 64'(e.data));
    end else begin
      check("rvalid_idle", 64'(rvalid_o), 64'(0));
    end
    if (!m_run) begin
      check("init_bus",
            64'({gnt_o, init_done_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o}),
            64'({2'b00, 1'b0, 1'b1, 1'b1, AW'(m_cnt), 32'h0, 4'hF}));
      ref_mem[m_cnt] = '0;
      if (m_cnt == NW - 1) m_run = 1'b1;
      m_cnt++;
      init_cycles++;
    end else begin
      w = -1;
      for (int i = 0; i < NR; i++) begin
        j = (m_ptr + i) % NR;
        if (w < 0 && req[j]) w = j;
      end
      eg = (w < 0) ? '0 : NR'(1) << w;
      check("gnt", 64'(gnt_o), 64'(eg));
      check("init_done", 64'(init_done_o), 64'(1));
      if (w >= 0) begin
        a = int'(addr[w]);
        check("mem_bus",
              64'({mem_req_o, mem_we_o, mem_addr_o, mem_be_o}),
              64'({1'b1, we[w], addr[w], be[w]}));
        check("mem_wdata", 64'(mem_wdata_o), 64'(wdata[w]));
        e.idx  = w;
        e.data = we[w] ? '0 : ref_mem[a];
        q.push_back(e);
        if (we[w])
          for (int b = 0; b < BW; b++)
            if (be[w][b]) ref_mem[a][b*8 +: 8] = wdata[w][b*8 +: 8];
        m_ptr = (w + 1) % NR;
      end else begin
        check("mem_idle",
              64'({mem_req_o, mem_we_o, mem_addr_o, mem_be_o}), 64'(0));
        check("mem_idle_wdata", 64'(mem_wdata_o), 64'(0));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    q.delete();
    m_run = 1'b0;
    m_cnt = 0;
    m_ptr = 0;
    init_cycles = 0;
    req = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("reset_outs", 64'({mem_req_o, gnt_o, rvalid_o, init_done_o}), 64'(0));
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  // Run the zero sweep; req_at >= 0 raises a read by req0 at that sweep cycle.
  task automatic sweep(input int req_at);
    int guard;
    guard = 0;
    while (!m_run && guard < 1000) begin
      if (init_cycles == req_at) begin
        req[0]  = 1'b1;
        we[0]   = 1'b0;
        addr[0] = 9'h1FF;
        be[0]   = 4'hF;
      end
      step();
      guard++;
    end
    check("sweep_len", 64'(init_cycles), 64'(NW));
  endtask

  typedef struct {
    logic [NR-1:0] req;
    logic [NR-1:0] we;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic [BW-1:0] b0, b1;
    logic [NR-1:0] egnt, erv;
    logic [DW-1:0] erd;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] rq, input logic [1:0] w,
                              input logic [8:0] a0, input logic [31:0] d0, input logic [3:0] b0,
                              input logic [8:0] a1, input logic [31:0] d1, input logic [3:0] b1,
                              input logic [1:0] eg, input logic [1:0] ev, input logic [31:0] ed);
    vec_t v;
    v.req = rq; v.we = w; v.a0 = a0; v.d0 = d0; v.b0 = b0;
    v.a1 = a1; v.d1 = d1; v.b1 = b1; v.egnt = eg; v.erv = ev; v.erd = ed;
    return v;
  endfunction

  vec_t tbl [19];
  int   gnt_seen;

  initial begin
    req = '0; we = '0; addr = '0; wdata = '0; be = '0;
    rst = 1'b1;

    tbl[0]  = mk(2'b01, 2'b00, 9'h1A5, 32'h0, 4'hF, 9'h0, 32'h0, 4'hF, 2'b01, 2'b00, 32'h0);
    tbl[1]  = mk(2'b01, 2'b01, 9'h007, 32'hDEADBEEF, 4'b0101, 9'h0, 32'h0, 4'hF, 2'b01, 2'b01, 32'h0);
    tbl[2]  = mk(2'b01, 2'b00, 9'h007, 32'h0, 4'hF, 9'h0, 32'h0, 4'hF, 2'b01, 2'b01, 32'h0);
    tbl[3]  = mk(2'b10, 2'b00, 9'h000, 32'h0, 4'hF, 9'h7, 32'h0, 4'hF, 2'b10, 2'b01, 32'h00AD00EF);
    tbl[4]  = mk(2'b00, 2'b00, 9'h000, 32'h0, 4'hF, 9'h0, 32'h0, 4'hF, 2'b00, 2'b10, 32'h00AD00EF);
    tbl[5]  = mk(2'b11, 2'b00, 9'h007, 32'h0, 4'hF, 9'h3, 32'h0, 4'hF, 2'b01, 2'b00, 32'h0);
    tbl[6]  = mk(2'b11, 2'b00, 9'h007, 32'h0, 4'hF, 9'h3, 32'h0, 4'hF, 2'b10, 2'b01, 32'h00AD00EF);
    tbl[7]  = mk(2'b11, 2'b00, 9'h007, 32'h0, 4'hF, 9'h3, 32'h0, 4'hF, 2'b01, 2'b10, 32'h0);
    tbl[8]  = mk(2'b11, 2'b00, 9'h007, 32'h0, 4'hF, 9'h3, 32'h0, 4'hF, 2'b10, 2'b01, 32'h00AD00EF);
    tbl[9]  = mk(2'b11, 2'b00, 9'h007, 32'h0, 4'hF, 9'h3, 32'h0, 4'hF, 2'b01, 2'b10, 32'h0);
    tbl[10] = mk(2'b11, 2'b00, 9'h007, 32'h0, 4'hF, 9'h3, 32'h0, 4'hF, 2'b10, 2'b01, 32'h00AD00EF);
    tbl[11] = mk(2'b10, 2'b10, 9'h000, 32'h0, 4'hF, 9'h3, 32'h11111111, 4'hF, 2'b10, 2'b10, 32'h0);
    tbl[12] = mk(2'b10, 2'b10, 9'h000, 32'h0, 4'hF, 9'h4, 32'h22222222, 4'hF, 2'b10, 2'b10, 32'h0);
    tbl[13] = mk(2'b10, 2'b10, 9'h000, 32'h0, 4'hF, 9'h5, 32'h33333333, 4'hF, 2'b10, 2'b10, 32'h0);
    tbl[14] = mk(2'b10, 2'b00, 9'h000, 32'h0, 4'hF, 9'h3, 32'h0, 4'hF, 2'b10, 2'b10, 32'h0);
    tbl[15] = mk(2'b10, 2'b00, 9'h000, 32'h0, 4'hF, 9'h4, 32'h0, 4'hF, 2'b10, 2'b10, 32'h11111111);
    tbl[16] = mk(2'b10, 2'b00, 9'h000, 32'h0, 4'hF, 9'h5, 32'h0, 4'hF, 2'b10, 2'b10, 32'h22222222);
    tbl[17] = mk(2'b00, 2'b00, 9'h000, 32'h0, 4'hF, 9'h0, 32'h0, 4'hF, 2'b00, 2'b10, 32'h33333333);
    tbl[18] = mk(2'b00, 2'b00, 9'h000, 32'h0, 4'hF, 9'h0, 32'h0, 4'hF, 2'b00, 2'b00, 32'h0);

    do_reset(2);
    sweep(-1);

    for (int i = 0; i < 19; i++) begin
      req = tbl[i].req;
      we  = tbl[i].we;
      addr[0] = tbl[i].a0; wdata[0] = tbl[i].d0; be[0] = tbl[i].b0;
      addr[1] = tbl[i].a1; wdata[1] = tbl[i].d1; be[1] = tbl[i].b1;
      step();
      check($sformatf("tbl%0d_gnt", i), 64'(s_gnt), 64'(tbl[i].egnt));
      check($sformatf("tbl%0d_rv", i), 64'(s_rv), 64'(tbl[i].erv));
      check($sformatf("tbl%0d_rd", i), 64'(s_rd), 64'(tbl[i].erd));
    end

    // Request raised at sweep cycle 10 must wait for the first RUN cycle.
    do_reset(1);
    sweep(10);
    step();
    check("first_run_gnt", 64'(s_gnt), 64'(2'b01));
    req = '0;
    step();
    check("first_run_rv", 64'({s_rv, s_rd}), 64'({2'b01, 32'h0}));

    // Reset pulse in the middle of the sweep restarts it from address 0.
    do_reset(1);
    gnt_seen = 0;
    while (m_cnt < 200 && gnt_seen < 1000) begin
      step();
      gnt_seen++;
    end
    do_reset(2);
    sweep(-1);

    // Reset right after a RUN read grant discards the pending response.
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 9'd9; be[1] = 4'hF;
    step();
    check("pre_reset_gnt", 64'(s_gnt), 64'(2'b10));
    req = '0;
    do_reset(1);
    sweep(-1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
